// File: rtl/decimal_entry_bcd_encoder.sv
// Decimal keypad entry register: encodes 10-line key presses into BCD digits and
// shifts them into a DIGITS-wide entry with backspace, clear and overflow tracking.
module decimal_entry_bcd_encoder #(
    parameter int DIGITS   = 4,
    parameter int PRIORITY = 0,
    parameter int OVF_MODE = 0,
    localparam int CW      = $clog2(DIGITS + 1),
    localparam int BW      = 4 * DIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    key_d,
    input  logic          key_valid,
    input  logic          clr,
    input  logic          bs,
    output logic [BW-1:0] bcd_out,
    output logic [CW-1:0] count,
    output logic [3:0]    digit_y,
    output logic          err,
    output logic          full,
    output logic          ovf
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(DIGITS);

    // Returns {valid, digit}. The highest set index is tracked in both modes;
    // strict mode additionally demands exactly one line asserted.
    function automatic logic [4:0] encode_key(input logic [9:0] k);
        logic [3:0] idx;
        int         ones;
        idx  = 4'd0;
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                idx  = 4'(i);
                ones = ones + 1;
            end
        end
        if (PRIORITY != 0) begin
            return {(ones != 0), idx};
        end
        return {(ones == 1), idx};
    endfunction

    logic [BW-1:0] bcd_p1;
    logic [CW-1:0] count_p1;
    logic [3:0]    digit_y_p1;
    logic          err_p1;
    logic          ovf_p1;

    logic [4:0]    enc_p0;
    logic          key_ok_p0;
    logic [3:0]    digit_p0;
    logic          full_p0;
    logic [BW-1:0] bcd_shl_p0;
    logic [BW-1:0] bcd_shr_p0;

    // Stage p0: decode the key lines and precompute both shift directions
    always_comb begin
        enc_p0     = encode_key(key_d);
        key_ok_p0  = enc_p0[4];
        digit_p0   = enc_p0[3:0];
        full_p0    = (count_p1 == COUNT_MAX);
        bcd_shl_p0 = (bcd_p1 << 4) | BW'(digit_p0);
        bcd_shr_p0 = bcd_p1 >> 4;
    end

    // Stage p1: entry state, updated by the single highest-priority event
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_p1     <= '0;
            count_p1   <= '0;
            digit_y_p1 <= 4'd0;
            err_p1     <= 1'b0;
            ovf_p1     <= 1'b0;
        end else begin
            err_p1 <= 1'b0;
            if (clr) begin
                bcd_p1     <= '0;
                count_p1   <= '0;
                digit_y_p1 <= 4'd0;
                ovf_p1     <= 1'b0;
            end else if (bs) begin
                if (count_p1 != '0) begin
                    bcd_p1     <= bcd_shr_p0;
                    count_p1   <= count_p1 - CW'(1);
                    digit_y_p1 <= bcd_shr_p0[3:0];
                end
            end else if (key_valid) begin
                if (!key_ok_p0) begin
                    err_p1 <= 1'b1;
                end else if (!full_p0) begin
                    bcd_p1     <= bcd_shl_p0;
                    count_p1   <= count_p1 + CW'(1);
                    digit_y_p1 <= digit_p0;
                end else begin
                    ovf_p1 <= 1'b1;
                    // Shift mode discards the oldest digit; drop mode keeps the entry intact
                    if (OVF_MODE != 0) begin
                        bcd_p1     <= bcd_shl_p0;
                        digit_y_p1 <= digit_p0;
                    end
                end
            end
        end
    end

    assign bcd_out = bcd_p1;
    assign count   = count_p1;
    assign digit_y = digit_y_p1;
    assign err     = err_p1;
    assign ovf     = ovf_p1;
    assign full    = full_p0;

endmodule

// File: tb/tb_decimal_entry_bcd_encoder.sv
// Directed bench: three instances (strict/drop, priority/drop, strict/shift) share
// one stimulus stream; each check targets the instance the scenario concerns.
module tb_decimal_entry_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  key_d;
    logic        key_valid;
    logic        clr;
    logic        bs;

    logic [15:0] bcd_d, bcd_p, bcd_o;
    logic [2:0]  cnt_d, cnt_p, cnt_o;
    logic [3:0]  dy_d, dy_p, dy_o;
    logic        err_d, err_p, err_o;
    logic        full_d, full_p, full_o;
    logic        ovf_d, ovf_p, ovf_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decimal_entry_bcd_encoder #(.DIGITS(4), .PRIORITY(0), .OVF_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .key_d(key_d), .key_valid(key_valid), .clr(clr), .bs(bs),
        .bcd_out(bcd_d), .count(cnt_d), .digit_y(dy_d), .err(err_d), .full(full_d), .ovf(ovf_d)
    );

    decimal_entry_bcd_encoder #(.DIGITS(4), .PRIORITY(1), .OVF_MODE(0)) u_pri (
        .clk(clk), .rst(rst), .key_d(key_d), .key_valid(key_valid), .clr(clr), .bs(bs),
        .bcd_out(bcd_p), .count(cnt_p), .digit_y(dy_p), .err(err_p), .full(full_p), .ovf(ovf_p)
    );

    decimal_entry_bcd_encoder #(.DIGITS(4), .PRIORITY(0), .OVF_MODE(1)) u_ovf (
        .clk(clk), .rst(rst), .key_d(key_d), .key_valid(key_valid), .clr(clr), .bs(bs),
        .bcd_out(bcd_o), .count(cnt_o), .digit_y(dy_o), .err(err_o), .full(full_o), .ovf(ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        key_valid = 1'b0;
        key_d     = 10'd0;
        clr       = 1'b0;
        bs        = 1'b0;
    endtask

    task automatic press(input logic [9:0] k);
        key_d     = k;
        key_valid = 1'b1;
        tick();
    endtask

    task automatic press_digit(input int d);
        logic [9:0] k;
        k = 10'd1 << d;
        press(k);
    endtask

    task automatic backspace();
        bs = 1'b1;
        tick();
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; key_d = 10'd0; key_valid = 1'b0; clr = 1'b0; bs = 1'b0;
        @(posedge clk);
        rst = 1'b1;
        tick();

        // Reset state
        chk("rst_bcd",   bcd_d,  0);
        chk("rst_count", cnt_d,  0);
        chk("rst_digit", dy_d,   0);
        chk("rst_err",   err_d,  0);
        chk("rst_full",  full_d, 0);
        chk("rst_ovf",   ovf_d,  0);

        // S1: back-to-back entry of 1, 5, 9
        press(10'b0000000010);
        chk("s1_lat_bcd", bcd_d, 16'h0001);
        chk("s1_lat_cnt", cnt_d, 1);
        press(10'b0000100000);
        chk("s1_mid_bcd", bcd_d, 16'h0015);
        press(10'b1000000000);
        chk("s1_bcd",   bcd_d, 16'h0159);
        chk("s1_count", cnt_d, 3);
        chk("s1_digit", dy_d,  4'h9);
        chk("s1_err",   err_d, 0);
        chk("s1_pri_bcd", bcd_p, 16'h0159);

        // S5: backspace down to empty, then one more on empty
        backspace();
        chk("s5_bs1_bcd",   bcd_d, 16'h0015);
        chk("s5_bs1_count", cnt_d, 2);
        chk("s5_bs1_digit", dy_d,  4'h5);
        backspace();
        chk("s5_bs2_digit", dy_d, 4'h1);
        backspace();
        chk("s5_bs3_bcd",   bcd_d, 16'h0000);
        chk("s5_bs3_count", cnt_d, 0);
        backspace();
        chk("s5_bs4_bcd",   bcd_d, 16'h0000);
        chk("s5_bs4_count", cnt_d, 0);
        chk("s5_bs4_err",   err_d, 0);

        // S2: strict mode rejects two lines and no lines
        press(10'b0000000011);
        chk("s2_two_err",  err_d, 1);
        chk("s2_two_bcd",  bcd_d, 16'h0000);
        chk("s2_two_cnt",  cnt_d, 0);
        chk("s2_pri_bcd",  bcd_p, 16'h0001);
        tick();
        chk("s2_err_once", err_d, 0);
        press(10'b0000000000);
        chk("s2_zero_err", err_d, 1);
        chk("s2_zero_bcd", bcd_d, 16'h0000);
        chk("s2_pri_zero_err", err_p, 1);

        // S3: priority mode takes the highest line
        press(10'b0000100110);
        chk("s3_pri_digit", dy_p,  4'h5);
        chk("s3_pri_bcd",   bcd_p, 16'h0015);
        chk("s3_pri_err",   err_p, 0);
        chk("s3_strict_err", err_d, 1);
        press(10'b0000000000);
        chk("s3_pri_zero_err", err_p, 1);
        chk("s3_pri_zero_bcd", bcd_p, 16'h0015);

        // S5: clear wins over a simultaneous key
        key_d = 10'b0000001000; key_valid = 1'b1; clr = 1'b1;
        tick();
        chk("s5_clr_pri_bcd", bcd_p, 0);
        chk("s5_clr_pri_cnt", cnt_p, 0);
        chk("s5_clr_pri_dig", dy_p,  0);
        chk("s5_clr_err",     err_p, 0);
        chk("s5_clr_dut_bcd", bcd_d, 0);

        // S4: overflow in both modes, invalid key while full first
        for (int d = 1; d <= 4; d++) press_digit(d);
        chk("s4_full_d",   full_d, 1);
        chk("s4_full_ovf0", ovf_d, 0);
        press(10'b0000000011);
        chk("s4_inv_err",  err_d, 1);
        chk("s4_inv_ovf",  ovf_d, 0);
        chk("s4_inv_bcd",  bcd_d, 16'h1234);
        press_digit(5);
        chk("s4_m0_bcd",   bcd_d, 16'h1234);
        chk("s4_m0_full",  full_d, 1);
        chk("s4_m0_ovf",   ovf_d, 1);
        chk("s4_m0_digit", dy_d,  4'h4);
        chk("s4_m1_bcd",   bcd_o, 16'h2345);
        chk("s4_m1_count", cnt_o, 4);
        chk("s4_m1_ovf",   ovf_o, 1);
        chk("s4_m1_digit", dy_o,  4'h5);
        tick();
        chk("s4_ovf_sticky", ovf_d, 1);
        clear();
        chk("s4_clr_ovf",  ovf_d, 0);
        chk("s4_clr_full", full_d, 0);

        // S6: reset in the same cycle as a key drops that key
        press_digit(7);
        press_digit(8);
        chk("s6_pre_bcd", bcd_d, 16'h0078);
        key_d = 10'b0000001000; key_valid = 1'b1; rst = 1'b1;
        tick();
        chk("s6_rst_bcd",   bcd_d, 0);
        chk("s6_rst_count", cnt_d, 0);
        chk("s6_rst_digit", dy_d,  0);
        press_digit(6);
        chk("s6_next_count", cnt_d, 1);
        chk("s6_next_bcd",   bcd_d, 16'h0006);

        // Backspace outranks a simultaneous key
        key_d = 10'b1000000000; key_valid = 1'b1; bs = 1'b1;
        tick();
        chk("bs_pri_count", cnt_d, 0);
        chk("bs_pri_bcd",   bcd_d, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decimal_entry_bcd_encoder.md
DECIMAL_ENTRY_BCD_ENCODER -- requirements
Module: decimal_entry_bcd_encoder

Interface
REQ-001 Parameter DIGITS, default 4, meaning number of BCD digits held; legal range 1..8.
REQ-002 Parameter PRIORITY, default 0, meaning encode mode: 0 = strict one-hot, 1 = highest set bit wins.
REQ-003 Parameter OVF_MODE, default 0, meaning full behaviour: 0 = drop new digit, 1 = shift out oldest digit.
REQ-004 Local width CW SHALL be $clog2(DIGITS+1).
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1, meaning synchronous active-high reset.
REQ-008 Port key_d, input, 10, meaning decimal key lines; bit k = digit k.
REQ-009 Port key_valid, input, 1, meaning key_d is sampled this cycle.
REQ-010 Port clr, input, 1, meaning synchronous clear of the entry.
REQ-011 Port bs, input, 1, meaning backspace: remove the newest digit.
REQ-012 Port bcd_out, output, 4*DIGITS, meaning the entered number; newest digit in [3:0].
REQ-013 Port count, output, CW, meaning number of digits held, 0..DIGITS.
REQ-014 Port digit_y, output, 4, meaning the last accepted BCD digit.
REQ-015 Port err, output, 1, meaning one-cycle pulse on an invalid key.
REQ-016 Port full, output, 1, meaning count == DIGITS (combinational from count).
REQ-017 Port ovf, output, 1, meaning sticky flag: a key arrived while full.

Function
REQ-018 Strict mode (PRIORITY=0): key_d SHALL be valid only with exactly one bit set; the digit is that bit's index.
REQ-019 Priority mode (PRIORITY=1): the digit SHALL be the index of the highest set bit; key_d == 0 is invalid.
REQ-020 Encoding: the digit SHALL be 4-bit binary 0000..1001; no other code is produced.
REQ-021 Event priority per cycle: rst > clr > bs > key_valid; all lower-priority inputs that cycle SHALL be ignored.
REQ-022 Valid key, not full: bcd_out <= {bcd_out[4*DIGITS-5:0], digit}; count += 1; digit_y <= digit; visible the cycle after key_valid (latency 1).
REQ-023 Invalid key: err = 1 for exactly the next cycle; bcd_out, count, digit_y and ovf unchanged.
REQ-024 Valid key, full, OVF_MODE=0: no shift; count, bcd_out and digit_y unchanged; ovf <= 1.
REQ-025 Valid key, full, OVF_MODE=1: shift as REQ-022 (oldest digit lost); count stays DIGITS; digit_y <= digit; ovf <= 1.
REQ-026 bs with count > 0: bcd_out <= {4'b0000, bcd_out[4*DIGITS-1:4]}; count -= 1; digit_y <= new bcd_out[3:0].
REQ-027 bs with count == 0: no state change and no err.
REQ-028 clr: bcd_out, count, digit_y and ovf SHALL be cleared to 0; err = 0.
REQ-029 Invalid key while full: SHALL behave as REQ-023; ovf is not set.
REQ-030 err SHALL never assert for two consecutive cycles unless invalid keys arrive on consecutive cycles.
REQ-031 Back-to-back valid keys on every cycle SHALL each be accepted, with no bubble.

Reset
REQ-032 When rst is high at a clock edge: bcd_out = 0, count = 0, digit_y = 0, err = 0, ovf = 0, and full = 0 (for DIGITS >= 1).
REQ-033 rst asserted during a key_valid cycle SHALL drop that key; no partial update.

Verification
REQ-034 Bench SHALL use DIGITS=4 unless noted, and cover these directed scenarios:
- S1 Entry: keys 10'b0000000010, 10'b0000100000, 10'b1000000000 on consecutive cycles -> bcd_out = 16'h0159, count = 3, digit_y = 4'h9, err = 0.
- S2 Invalid, strict mode: PRIORITY=0, key 10'b0000000011 -> err pulses for 1 cycle; bcd_out unchanged. Key 10'b0 -> same result.
- S3 Priority mode: PRIORITY=1, key 10'b0000100110 -> digit_y = 4'h5; key 10'b0 -> err pulse.
- S4 Overflow:
  - OVF_MODE=0: keys 1,2,3,4,5 -> bcd_out = 16'h1234, full = 1, ovf = 1.
  - OVF_MODE=1: same keys -> bcd_out = 16'h2345, count = 4, ovf = 1.
- S5 Backspace and clr:
  - From 16'h0159, bs -> 16'h0015, count = 2, digit_y = 5.
  - bs three more times -> 0, count = 0, no err.
  - clr together with key_valid -> all outputs 0 and the key is dropped.
- S6 Reset mid-entry: rst together with key_valid after two digits -> all outputs 0 next cycle; the following valid key gives count = 1.
